demux_bus_arbiter: RTL and testbench

//  - Round-robin arbiter sharing the 1-to-16 line demux (val/sel -> 16 tri-state lines) among NREQ requesters.
//  - Latches the winner's destination onto sel, forwards its data bit onto val and asserts bus_en.
//  - Inserts one dead cycle between owners so two sources never drive the lines in the same cycle.
//  - Sits between the processor's bit-write sources and the line demux.

---
 rtl/demux_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/demux_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_demux_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demux_arb_pkg: shared types and constants for the line-demux bus arbiter |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package demux_arb_pkg;

    localparam int SEL_W = 4;
    localparam int LINES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick: combinational round-robin picker, scans req upward from ptr     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_pick
    import demux_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic [PTR_W-1:0] w,
    output logic             any
);

    int idx;

    always_comb begin
        win = '0;
        w   = '0;
        any = 1'b0;
        idx = 0;
        // Scan from the farthest offset down so the nearest request to ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                win      = '0;
                win[idx] = 1'b1;
                w        = PTR_W'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demux_bus_arbiter: round-robin owner of the 1-to-16 line demux with one  |
// | dead cycle between owners. ARB_TIMEOUT_EN adds a MAX_HOLD grant limit.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module demux_bus_arbiter
    import demux_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [SEL_W*NREQ-1:0] dest,
    input  logic [NREQ-1:0]       bit_in,
    output logic [NREQ-1:0]       gnt,
    output logic [SEL_W-1:0]      sel,
    output logic                  val,
    output logic                  bus_en,
    output logic                  busy,
    output logic                  timeout
);

    localparam int PTR_W = $clog2(NREQ);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  own_q, own_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              val_q, val_d;
    logic              bus_en_q, bus_en_d;
    logic              timeout_q, timeout_d;

    logic [NREQ-1:0]   pick_win;
    logic [PTR_W-1:0]  pick_w;
    logic              pick_any;
    logic              own_req;
    logic              hold_expired;
    logic              own_release;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .win (pick_win),
        .w   (pick_w),
        .any (pick_any)
    );

    assign own_req     = req[own_q];
    assign own_release = (state_q == OWN) && (!own_req || hold_expired);

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    // hold_q counts OWN cycles already completed by the current owner.
    assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        hold_d = '0;
        if (state_q == OWN && !own_release) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_expired = 1'b0;

    // MAX_HOLD has no effect in this build.
    if (MAX_HOLD < 1) begin : g_max_hold_unused
    end
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        own_d     = own_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        val_d     = val_q;
        bus_en_d  = bus_en_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d  = OWN;
                    own_d    = pick_w;
                    gnt_d    = pick_win;
                    sel_d    = dest[int'(pick_w)*SEL_W +: SEL_W];
                    val_d    = bit_in[pick_w];
                    bus_en_d = 1'b1;
                end
            end
            OWN: begin
                if (own_release) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    bus_en_d  = 1'b0;
                    ptr_d     = PTR_W'(rr_next(int'(own_q), NREQ));
                    // A release with req still high can only be the forced one.
                    timeout_d = own_req;
                end else begin
                    val_d = bit_in[own_q];
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            own_q     <= '0;
            gnt_q     <= '0;
            sel_q     <= '0;
            val_q     <= 1'b0;
            bus_en_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            val_q     <= val_d;
            bus_en_q  <= bus_en_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign val     = val_q;
    assign bus_en  = bus_en_q;
    assign busy    = (state_q != IDLE);
    assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_demux_bus_arbiter: directed and randomized bench for the demux arbiter|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_demux_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 8;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [3:0]  req    = '0;
    logic [15:0] dest   = '0;
    logic [3:0]  bit_in = '0;
    logic [3:0]  gnt;
    logic [3:0]  sel;
    logic        val;
    logic        bus_en;
    logic        busy;
    logic        timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: next round-robin start and the last values put on the lines.
    int         m_ptr    = 0;
    logic [3:0] last_sel = '0;
    logic       last_val = 1'b0;
    int         round_len  [4];
    logic [3:0] round_dest [4];

    wire [11:0] obs = {gnt, sel, val, bus_en, busy, timeout};

    demux_bus_arbiter #(
        .NREQ     (NREQ),
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .dest    (dest),
        .bit_in  (bit_in),
        .gnt     (gnt),
        .sel     (sel),
        .val     (val),
        .bus_en  (bus_en),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = '0;
        dest   = '0;
        bit_in = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== 12'h000) begin
            $display("FAIL reset_outputs actual=%h required=%h", obs, 12'h000);
            n_fail++;
        end
        rst_n    = 1'b1;
        m_ptr    = 0;
        last_sel = '0;
        last_val = 1'b0;
    endtask

    // One arbitration round: requesters in m raise req together, each keeps it up for
    // round_len[i] granted cycles, then idle_after quiet cycles follow.
    task automatic run_round(input logic [3:0] m, input int idle_after);
        int         ord[$];
        int         start[$];
        logic [3:0] bit_hist[$];
        logic [3:0] dest0 [4];
        logic [3:0] b;
        logic [11:0] exp_v;
        logic       gap_hit;
        int s, t_total, cur, o;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            if (m[(m_ptr + k) % 4]) ord.push_back((m_ptr + k) % 4);
        end
        foreach (ord[j]) begin
            start.push_back(s);
            s = s + round_len[ord[j]] + 2;
        end
        t_total = s + idle_after;
        for (int i = 0; i < 4; i++) begin
            dest0[i]        = round_dest[i];
            dest[i*4 +: 4]  = round_dest[i];
        end
        for (int t = 0; t < t_total; t++) begin
            req     = '0;
            cur     = -1;
            gap_hit = 1'b0;
            foreach (ord[j]) begin
                req[ord[j]] = (t < start[j] + round_len[ord[j]]);
                if (t >= start[j] && t < start[j] + round_len[ord[j]]) cur = j;
                if (t == start[j] + round_len[ord[j]]) gap_hit = 1'b1;
            end
            if (cur >= 0 && t > start[cur]) dest[ord[cur]*4 +: 4] = 4'($urandom);
            bit_in = 4'($urandom);
            bit_hist.push_back(bit_in);
            @(posedge clk);
            @(negedge clk);
            if (cur >= 0) begin
                o        = ord[cur];
                b        = bit_hist[t];
                last_sel = dest0[o];
                last_val = b[o];
                exp_v    = {4'(1 << o), last_sel, last_val, 3'b110};
            end else begin
                exp_v = {4'b0000, last_sel, last_val, 1'b0, gap_hit, 1'b0};
            end
            n_cmp++;
            if (obs !== exp_v) begin
                $display("FAIL round m=%b t=%0d actual=%h required=%h", m, t, obs, exp_v);
                n_fail++;
            end
        end
        if (ord.size() > 0) m_ptr = (ord[ord.size()-1] + 1) % 4;
    endtask

    task automatic test_reset();
        do_reset();
        req = 4'b0001; dest[3:0] = 4'd7; bit_in = 4'b0001;
        @(negedge clk);
        n_cmp++;
        if (obs !== {4'b0001, 4'd7, 4'b1110}) begin
            $display("FAIL reset_first_grant actual=%h required=%h", obs, {4'b0001, 4'd7, 4'b1110});
            n_fail++;
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);
        req = 4'b0011; dest[7:4] = 4'd4; bit_in = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (obs !== {4'b0010, 4'd4, 4'b0110}) begin
            $display("FAIL reset_second_grant actual=%h required=%h", obs, {4'b0010, 4'd4, 4'b0110});
            n_fail++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 12'h000) begin
            $display("FAIL reset_async_mid_own actual=%h required=%h", obs, 12'h000);
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== {4'b0001, 4'd7, 4'b0110}) begin
            $display("FAIL reset_ptr_zero actual=%h required=%h", obs, {4'b0001, 4'd7, 4'b0110});
            n_fail++;
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        logic [11:0] exp_v;
        do_reset();
        req = 4'b0001; dest[3:0] = 4'd5; bit_in = 4'b0001;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000) begin
            $display("FAIL single_same_cycle gnt actual=%b required=%b", gnt, 4'b0000);
            n_fail++;
        end
        for (int t = 0; t < 5; t++) begin
            req = (t < 3) ? 4'b0001 : 4'b0000;
            @(posedge clk);
            @(negedge clk);
            if (t < 3)       exp_v = {4'b0001, 4'd5, 4'b1110};
            else if (t == 3) exp_v = {4'b0000, 4'd5, 4'b1010};
            else             exp_v = {4'b0000, 4'd5, 4'b1000};
            n_cmp++;
            if (obs !== exp_v) begin
                $display("FAIL single t=%0d actual=%h required=%h", t, obs, exp_v);
                n_fail++;
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            round_len[i]  = 2;
            round_dest[i] = 4'($urandom);
        end
        run_round(4'b1111, 0);
        run_round(4'b1111, 1);
    endtask

    task automatic test_data_tracking();
        logic [11:0] exp_v;
        do_reset();
        dest[3:0] = 4'd3;
        for (int t = 0; t < 8; t++) begin
            req[0]    = (t < 6);
            bit_in[0] = t[0];
            if (t == 3) dest[3:0] = 4'd9;
            @(posedge clk);
            @(negedge clk);
            if (t < 6)       exp_v = {4'b0001, 4'd3, t[0], 3'b110};
            else if (t == 6) exp_v = {4'b0000, 4'd3, 1'b1, 3'b010};
            else             exp_v = {4'b0000, 4'd3, 1'b1, 3'b000};
            n_cmp++;
            if (obs !== exp_v) begin
                $display("FAIL data_tracking t=%0d actual=%h required=%h", t, obs, exp_v);
                n_fail++;
            end
        end
    endtask

    task automatic test_dest14();
        logic [11:0] exp_v;
        logic        b;
        do_reset();
        dest[11:8] = 4'd14;
        for (int t = 0; t < 4; t++) begin
            req[2]    = (t < 2);
            b         = 1'($urandom);
            bit_in[2] = b;
            @(posedge clk);
            @(negedge clk);
            if (t < 2) begin
                last_val = b;
                exp_v    = {4'b0100, 4'd14, b, 3'b110};
            end else begin
                exp_v = {4'b0000, 4'd14, last_val, 1'b0, (t == 2), 1'b0};
            end
            n_cmp++;
            if (obs !== exp_v) begin
                $display("FAIL dest14 t=%0d actual=%h required=%h", t, obs, exp_v);
                n_fail++;
            end
        end
    endtask

    task automatic test_timeout();
        logic [11:0] exp_v;
        logic [3:0]  b;
        logic [3:0]  dsel [2];
        int period, pos, o;
        do_reset();
        dsel[0] = 4'd2;
        dsel[1] = 4'd13;
        dest[3:0] = dsel[0];
        dest[7:4] = dsel[1];
        req       = 4'b0011;
        period    = MAX_HOLD + 2;
        for (int t = 0; t < 2 * period + 2; t++) begin
            b      = 4'($urandom);
            bit_in = b;
            @(posedge clk);
            @(negedge clk);
`ifdef ARB_TIMEOUT_EN
            pos = t % period;
            o   = (t / period) % 2;
            if (pos < MAX_HOLD) begin
                last_sel = dsel[o];
                last_val = b[o];
                exp_v    = {4'(1 << o), last_sel, last_val, 3'b110};
            end else begin
                exp_v = {4'b0000, last_sel, last_val, 1'b0, (pos == MAX_HOLD), (pos == MAX_HOLD)};
            end
`else
            pos   = t;
            o     = 0;
            exp_v = {4'b0001, dsel[o], b[o], 3'b110};
`endif
            n_cmp++;
            if (obs !== exp_v) begin
                $display("FAIL timeout t=%0d pos=%0d actual=%h required=%h", t, pos, obs, exp_v);
                n_fail++;
            end
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        repeat (12) begin
            for (int i = 0; i < 4; i++) begin
                round_len[i]  = $urandom_range(1, 5);
                round_dest[i] = 4'($urandom);
            end
            run_round(4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_data_tracking();
        test_dest14();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
